// File: rtl/com_to_2.sv
// Sign-controlled two's-complement converter with registered result and valid.
// Define COM_TO_2_FLAGS_EN to add the registered zero/ovf status outputs.
module com_to_2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic [WIDTH-1:0] a,
  input  logic             in_valid,
  output logic [WIDTH-1:0] neg_a,
  output logic             out_valid
`ifdef COM_TO_2_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_neg_a;
  logic             r_out_valid;

  // Carry out of the increment is dropped by the WIDTH-bit result.
  always_comb begin
    w_result = a;
    if (sin) w_result = ~a + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_a     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) r_neg_a <= w_result;
    end
  end

  assign neg_a     = r_neg_a;
  assign out_valid = r_out_valid;

`ifdef COM_TO_2_FLAGS_EN
  logic w_zero;
  logic w_ovf;
  logic r_zero;
  logic r_ovf;

  assign w_zero = (w_result == '0);
  assign w_ovf  = sin && (a == MOST_NEG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (in_valid) begin
      r_zero <= w_zero;
      r_ovf  <= w_ovf;
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`else
  logic w_unused;
  assign w_unused = ^MOST_NEG;
`endif

endmodule

// File: tb/tb_com_to_2.sv
// Directed self-checking bench for com_to_2 (WIDTH=4), one task per scenario.
// Flag checks are included when COM_TO_2_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_com_to_2;

  logic       clk;
  logic       rst;
  logic       sin;
  logic [3:0] a;
  logic       in_valid;
  logic [3:0] neg_a;
  logic       out_valid;
`ifdef COM_TO_2_FLAGS_EN
  logic       zero;
  logic       ovf;
`endif

  int unsigned n_pass;
  int unsigned n_total;

  com_to_2 #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sin      (sin),
    .a        (a),
    .in_valid (in_valid),
    .neg_a    (neg_a),
    .out_valid(out_valid)
`ifdef COM_TO_2_FLAGS_EN
    ,
    .zero     (zero),
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sin = 1'b1; a = 4'b0011; in_valid = 1'b1;
    step(); step();
    n_total++;
    if (neg_a !== 4'b0000) $display("FAIL reset_neg_a got %b want 0000", neg_a);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else n_pass++;
`ifdef COM_TO_2_FLAGS_EN
    n_total++;
    if ({zero, ovf} !== 2'b00) $display("FAIL reset_flags got %b want 00", {zero, ovf});
    else n_pass++;
`endif
    rst = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    logic [4:0] v;
    logic [3:0] exp_q;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      sin = v[4]; a = v[3:0]; in_valid = 1'b1;
      // Negation modelled as 16 - a modulo 16.
      exp_q = v[4] ? 4'((16 - int'(v[3:0])) % 16) : v[3:0];
      step();
      n_total++;
      if (neg_a !== exp_q) $display("FAIL sweep_%0d got %b want %b", i, neg_a, exp_q);
      else n_pass++;
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL sweep_valid_%0d got %b want 1", i, out_valid);
      else n_pass++;
`ifdef COM_TO_2_FLAGS_EN
      n_total++;
      if (zero !== (exp_q == 4'd0)) $display("FAIL sweep_zero_%0d got %b want %b", i, zero, exp_q == 4'd0);
      else n_pass++;
      n_total++;
      if (ovf !== (v == 5'b11000)) $display("FAIL sweep_ovf_%0d got %b want %b", i, ovf, v == 5'b11000);
      else n_pass++;
`endif
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_edges();
    logic [4:0] vin [3];
    logic [3:0] vexp[3];
    logic [1:0] vflg[3];
    vin[0] = 5'b10000; vexp[0] = 4'b0000; vflg[0] = 2'b10;
    vin[1] = 5'b11000; vexp[1] = 4'b1000; vflg[1] = 2'b01;
    vin[2] = 5'b01000; vexp[2] = 4'b1000; vflg[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      sin = vin[i][4]; a = vin[i][3:0]; in_valid = 1'b1;
      step();
      n_total++;
      if (neg_a !== vexp[i]) $display("FAIL edge_%0d got %b want %b", i, neg_a, vexp[i]);
      else n_pass++;
`ifdef COM_TO_2_FLAGS_EN
      n_total++;
      if ({zero, ovf} !== vflg[i]) $display("FAIL edge_flags_%0d got %b want %b", i, {zero, ovf}, vflg[i]);
      else n_pass++;
`else
      if (vflg[i] === 2'bxx) $display("edge flag table uninitialised");
`endif
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_hold();
    sin = 1'b1; a = 4'b0110; in_valid = 1'b1;
    step();
    n_total++;
    if (neg_a !== 4'b1010 || out_valid !== 1'b1)
      $display("FAIL hold_capture got %b/%b want 1010/1", neg_a, out_valid);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0; sin = 1'($urandom); a = 4'($urandom);
      step();
      n_total++;
      if (neg_a !== 4'b1010 || out_valid !== 1'b0)
        $display("FAIL hold_%0d got %b/%b want 1010/0", i, neg_a, out_valid);
      else n_pass++;
`ifdef COM_TO_2_FLAGS_EN
      n_total++;
      if ({zero, ovf} !== 2'b00) $display("FAIL hold_flags_%0d got %b want 00", i, {zero, ovf});
      else n_pass++;
`endif
    end
  endtask

  task automatic test_async_reset();
    sin = 1'b1; a = 4'b0101; in_valid = 1'b1;
    step();
    n_total++;
    if (neg_a !== 4'b1011 || out_valid !== 1'b1)
      $display("FAIL async_pre got %b/%b want 1011/1", neg_a, out_valid);
    else n_pass++;
    sin = 1'b0; a = 4'b0111;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (neg_a !== 4'b0000 || out_valid !== 1'b0)
      $display("FAIL async_immediate got %b/%b want 0000/0", neg_a, out_valid);
    else n_pass++;
    step();
    n_total++;
    if (neg_a !== 4'b0000 || out_valid !== 1'b0)
      $display("FAIL async_held got %b/%b want 0000/0", neg_a, out_valid);
    else n_pass++;
    rst = 1'b0; sin = 1'b1; a = 4'b0001; in_valid = 1'b1;
    step();
    n_total++;
    if (neg_a !== 4'b1111 || out_valid !== 1'b1)
      $display("FAIL async_recover got %b/%b want 1111/1", neg_a, out_valid);
    else n_pass++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0] vin [3];
    logic [3:0] vexp[3];
    vin[0] = 5'b10010; vexp[0] = 4'b1110;
    vin[1] = 5'b00111; vexp[1] = 4'b0111;
    vin[2] = 5'b10111; vexp[2] = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      sin = vin[i][4]; a = vin[i][3:0]; in_valid = 1'b1;
      step();
      n_total++;
      if (neg_a !== vexp[i] || out_valid !== 1'b1)
        $display("FAIL b2b_%0d got %b/%b want %b/1", i, neg_a, out_valid, vexp[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    step();
    n_total++;
    if (out_valid !== 1'b0 || neg_a !== 4'b1001)
      $display("FAIL b2b_tail got %b/%b want 1001/0", neg_a, out_valid);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; sin = 1'b0; a = 4'b0000; in_valid = 1'b0;
    test_reset();
    test_sweep();
    test_edges();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/com_to_2.md
Name: com_to_2

Overview:
- Sign-controlled two's-complement converter for a WIDTH-bit operand.
- sin=1: output is the two's complement (negation) of operand a, modulo 2^WIDTH. sin=0: output equals a unchanged.
- Registered output with a simple valid qualifier.
- Sits in the arithmetic datapath ahead of adders/subtractors that consume signed operands.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  sign/negate control: 1 = negate a, 0 = pass a through.
- a  input  WIDTH  operand; a[WIDTH-1] is the MSB (A3 for WIDTH=4).
- in_valid  input  1  qualifies sin and a for capture this cycle.
- neg_a  output  WIDTH  registered result; neg_a[WIDTH-1] corresponds to -A3.
- out_valid  output  1  high for one cycle when neg_a holds a new result.

Behaviour:
- Reset (rst=1, asynchronous, takes effect without a clock edge): neg_a=0, out_valid=0. Outputs hold these values while rst stays high.
- Conversion function, evaluated combinationally from sin and a:
  - sin=0: result = a.
  - sin=1: result = (~a + 1) truncated to WIDTH bits; the carry out is discarded.
- Capture: on each rising clk edge with in_valid=1, neg_a <= result and out_valid <= 1.
- Hold: on each rising clk edge with in_valid=0, neg_a holds its previous value and out_valid <= 0.
- Latency: exactly 1 clock from in_valid sample to out_valid. Throughput: 1 result per clock; back-to-back valid inputs produce back-to-back outputs.
- Boundary values:
  - a=0 with sin=1 gives 0.
  - a=2^(WIDTH-1) (1000 for WIDTH=4) with sin=1 gives the same value, 1000. This is not flagged in the base build.
  - a=all-ones with sin=1 gives 0...01.
- Reset asserted mid-stream: a pending capture is lost. Outputs go to 0/0 immediately. The first valid input after rst deasserts is captured normally on the next edge.
- No X propagation when in_valid=0: sin and a are ignored.
- No internal state other than the neg_a and out_valid registers (plus the flag registers when the optional feature is compiled in).

Optional Feature:
- Macro: COM_TO_2_FLAGS_EN.
- Defined: adds two registered outputs, updated under the same capture and reset rules as neg_a (reset value 0, hold when in_valid=0):
  - zero (1 bit): 1 when the result is all zeros.
  - ovf (1 bit): 1 when sin=1 and a=2^(WIDTH-1), i.e. the negation is not representable.
- Not defined: neither port exists; the rest of the behaviour is identical.

Test Plan:
- Exhaustive sweep, WIDTH=4: drive all 32 {sin,a} combinations in order, one per clock with in_valid=1 -> each output one cycle later matches the reference function. Examples: {0,0101} -> 0101; {1,0011} -> 1101; {1,1111} -> 0001.
- Edge operands: {1,0000} -> 0000 (zero=1 if COM_TO_2_FLAGS_EN); {1,1000} -> 1000 (ovf=1 if COM_TO_2_FLAGS_EN); {0,1000} -> 1000, ovf=0.
- Hold: capture {1,0110} -> 1010. Then in_valid=0 for 3 cycles with random sin/a -> neg_a stays 1010, out_valid=0.
- Async reset mid-stream: while streaming, assert rst between edges -> neg_a=0 and out_valid=0 immediately, before the next edge. Deassert rst, send {1,0001} -> 1111 one cycle later.
- Back-to-back: in_valid=1 for {1,0010}, {0,0111}, {1,0111} on consecutive clocks -> 1110, 0111, 1001 on consecutive cycles, out_valid continuously 1.
